// File: rtl/scoreboard_pkg.sv
// Shared types for the multi-packet scoreboard: slot state encoding and slot-index sizing.
// No logic, no latency, no backpressure.
// Imported by the slot, the bus interface and the scoreboard top.
package scoreboard_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRACKING = 2'd1,
        DONE     = 2'd2
    } slot_state_t;

    // A single-slot build still needs a 1-bit index port.
    function automatic int min_slot_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_packet_scoreboard_if.sv
// Observed push/pop/data stream of the monitored in-order DUT.
// Pure wiring, zero latency.
// No backpressure: the monitor only listens.
interface multi_packet_scoreboard_if #(
    parameter int WIDTH = 8
) ();
    logic             push;
    logic             pop;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;

    modport master (output push, pop, start, data_in, data_out);
    modport slave  (input  push, pop, start, data_in, data_out);
endinterface

// File: rtl/scoreboard_slot.sv
// One tracked magic packet: stored data plus its 1-based distance from the DUT head.
// Capture registered; exit strobe combinational from state and the current pop.
// No backpressure: capture is only requested by the allocator while the slot is IDLE.
module scoreboard_slot
    import scoreboard_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int CNTWID = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              pop,
    input  logic [WIDTH-1:0]  cap_data,
    input  logic [CNTWID-1:0] cap_pos,
    output logic              idle,
    output logic              tracking,
    output logic              exit_now,
    output logic [WIDTH-1:0]  data
);
    slot_state_t       state_q, state_d;
    logic [CNTWID-1:0] pos_q, pos_d;
    logic [WIDTH-1:0]  data_q, data_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pos_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            data_q  <= data_d;
        end
    end

    // A slot captured this cycle is still IDLE here, so it cannot exit in the same cycle.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        data_d   = data_q;
        exit_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = TRACKING;
                    pos_d   = cap_pos;
                    data_d  = cap_data;
                end
            end
            TRACKING: begin
                if (pop) begin
                    if (pos_q == CNTWID'(1)) begin
                        exit_now = 1'b1;
                        state_d  = DONE;
                    end else begin
                        pos_d = pos_q - CNTWID'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign idle     = (state_q == IDLE);
    assign tracking = (state_q == TRACKING);
    assign data     = data_q;
endmodule

// File: rtl/multi_packet_scoreboard.sv
// Tracks up to NTRACK magic packets through an in-order DUT and flags data mismatches at exit.
// Exit strobe/prop_signal zero-latency to pop; occ, slots_busy and error flags one cycle later.
// No backpressure: passive monitor, overflow/underflow recorded as sticky errors.
module multi_packet_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int WIDTH   = 8,
    parameter int NTRACK  = 2,
    parameter int CNTWID  = $clog2(DEPTH + 1),
    parameter int SLOTWID = min_slot_width(NTRACK)
) (
    input  logic                       clk,
    input  logic                       rst,
    multi_packet_scoreboard_if.slave   bus,
    output logic                       data_out_vld,
    output logic [SLOTWID-1:0]         exit_slot,
    output logic                       prop_signal,
    output logic [CNTWID-1:0]          occ,
    output logic [NTRACK-1:0]          slots_busy,
    output logic                       err_overflow,
    output logic                       err_underflow
);
    logic [CNTWID-1:0] occ_q, occ_d, cap_pos;
    logic              overflow, underflow, push_eff, pop_eff;
    logic              ovf_q, udf_q;
    logic [NTRACK-1:0] slot_idle, slot_tracking, capture_vec, exit_vec;
    logic [WIDTH-1:0]  slot_data [NTRACK];
    logic [WIDTH-1:0]  exit_data;
    logic              found;

    assign overflow  = bus.push & ~bus.pop & (occ_q == CNTWID'(DEPTH));
    assign underflow = bus.pop & (occ_q == '0);
    assign push_eff  = bus.push & ~overflow;
    assign pop_eff   = bus.pop & ~underflow;
    assign occ_d     = occ_q + CNTWID'(push_eff) - CNTWID'(pop_eff);
    // Position the new packet will hold once this cycle's pop has taken effect.
    assign cap_pos   = occ_q - CNTWID'(pop_eff) + CNTWID'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            ovf_q <= ovf_q | overflow;
            udf_q <= udf_q | underflow;
        end
    end

    always_comb begin
        capture_vec = '0;
        found       = 1'b0;
        for (int i = 0; i < NTRACK; i++) begin
            if (!found && slot_idle[i]) begin
                capture_vec[i] = bus.start & push_eff;
                found          = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NTRACK; g++) begin : g_slot
        scoreboard_slot #(
            .WIDTH  (WIDTH),
            .CNTWID (CNTWID)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .capture  (capture_vec[g]),
            .pop      (pop_eff),
            .cap_data (bus.data_in),
            .cap_pos  (cap_pos),
            .idle     (slot_idle[g]),
            .tracking (slot_tracking[g]),
            .exit_now (exit_vec[g]),
            .data     (slot_data[g])
        );
    end

    // Positions are unique, so exit_vec is at most one-hot and OR-encoding is exact.
    always_comb begin
        exit_slot = '0;
        exit_data = '0;
        for (int i = 0; i < NTRACK; i++) begin
            if (exit_vec[i]) begin
                exit_slot = exit_slot | SLOTWID'(i);
                exit_data = exit_data | slot_data[i];
            end
        end
    end

    assign data_out_vld  = |exit_vec;
    assign prop_signal   = ~data_out_vld | (exit_data == bus.data_out);
    assign occ           = occ_q;
    assign slots_busy    = slot_tracking;
    assign err_overflow  = ovf_q;
    assign err_underflow = udf_q;
endmodule

// File: tb/tb_multi_packet_scoreboard.sv
// Directed bench for multi_packet_scoreboard at DEPTH=4, NTRACK=2 with hand-computed expectations.
module tb_multi_packet_scoreboard;
    import scoreboard_pkg::*;

    localparam int DEPTH   = 4;
    localparam int WIDTH   = 8;
    localparam int NTRACK  = 2;
    localparam int CNTWID  = 3;
    localparam int SLOTWID = 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               data_out_vld;
    logic [SLOTWID-1:0] exit_slot;
    logic               prop_signal;
    logic [CNTWID-1:0]  occ;
    logic [NTRACK-1:0]  slots_busy;
    logic               err_overflow;
    logic               err_underflow;

    int total = 0;
    int bad   = 0;

    multi_packet_scoreboard_if #(.WIDTH(WIDTH)) bus ();

    multi_packet_scoreboard #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .NTRACK (NTRACK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .data_out_vld  (data_out_vld),
        .exit_slot     (exit_slot),
        .prop_signal   (prop_signal),
        .occ           (occ),
        .slots_busy    (slots_busy),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic cyc(input logic p, input logic po, input logic s,
                       input logic [7:0] di, input logic [7:0] dout);
        @(negedge clk);
        bus.push     = p;
        bus.pop      = po;
        bus.start    = s;
        bus.data_in  = di;
        bus.data_out = dout;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.push = 0; bus.pop = 0; bus.start = 0; bus.data_in = 0; bus.data_out = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (data_out_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", data_out_vld); end
        total++; if (exit_slot !== 1'b0) begin bad++; $display("FAIL reset_exit_slot got=%h exp=0", exit_slot); end
        total++; if (prop_signal !== 1'b1) begin bad++; $display("FAIL reset_prop got=%b exp=1", prop_signal); end
        total++; if (occ !== 3'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occ); end
        total++; if (slots_busy !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b exp=00", slots_busy); end
        total++; if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
            bad++; $display("FAIL reset_err got=%b%b exp=00", err_overflow, err_underflow); end
    endtask

    // Three plain pushes then a capture at position 4; pop 4 carries last_data.
    task automatic run_single(input logic [7:0] last_data, input logic exp_prop, input string tag);
        logic [7:0] pd;
        do_reset();
        for (int i = 1; i <= 3; i++) cyc(1, 0, 0, 8'(i), 8'h00);
        cyc(1, 0, 1, 8'hA5, 8'h00);
        for (int i = 1; i <= 4; i++) begin
            pd = (i == 4) ? last_data : 8'(i);
            cyc(0, 1, 0, 8'h00, pd);
            if (i == 1) begin
                total++; if (slots_busy !== 2'b01 || occ !== 3'd4) begin
                    bad++; $display("FAIL %s_busy_occ got=%b/%0d exp=01/4", tag, slots_busy, occ); end
            end
            if (i < 4) begin
                total++; if (data_out_vld !== 1'b0) begin
                    bad++; $display("FAIL %s_early_vld pop=%0d got=%b exp=0", tag, i, data_out_vld); end
            end else begin
                total++; if (data_out_vld !== 1'b1 || exit_slot !== 1'b0) begin
                    bad++; $display("FAIL %s_exit got=%b/%h exp=1/0", tag, data_out_vld, exit_slot); end
                total++; if (prop_signal !== exp_prop) begin
                    bad++; $display("FAIL %s_prop got=%b exp=%b", tag, prop_signal, exp_prop); end
            end
        end
        cyc(0, 0, 0, 8'h00, 8'h5A);
        total++; if (prop_signal !== 1'b1 || data_out_vld !== 1'b0) begin
            bad++; $display("FAIL %s_after got=%b/%b exp=1/0", tag, prop_signal, data_out_vld); end
        total++; if (slots_busy !== 2'b00 || occ !== 3'd0) begin
            bad++; $display("FAIL %s_final got=%b/%0d exp=00/0", tag, slots_busy, occ); end
    endtask

    task automatic test_single_match();
        run_single(8'hA5, 1'b1, "match");
    endtask

    task automatic test_single_mismatch();
        run_single(8'h5A, 1'b0, "mismatch");
    endtask

    task automatic test_two_captures();
        do_reset();
        cyc(1, 0, 1, 8'h11, 8'h00);
        cyc(1, 0, 1, 8'h22, 8'h00);
        cyc(0, 1, 0, 8'h00, 8'h11);
        total++; if (slots_busy !== 2'b11) begin bad++; $display("FAIL two_busy got=%b exp=11", slots_busy); end
        total++; if (data_out_vld !== 1'b1 || exit_slot !== 1'b0 || prop_signal !== 1'b1) begin
            bad++; $display("FAIL two_pop1 got=%b/%h/%b exp=1/0/1", data_out_vld, exit_slot, prop_signal); end
        cyc(0, 1, 0, 8'h00, 8'h22);
        total++; if (data_out_vld !== 1'b1 || exit_slot !== 1'b1 || prop_signal !== 1'b1) begin
            bad++; $display("FAIL two_pop2 got=%b/%h/%b exp=1/1/1", data_out_vld, exit_slot, prop_signal); end
        cyc(1, 0, 1, 8'h33, 8'h00);
        total++; if (slots_busy !== 2'b00 || occ !== 3'd0) begin
            bad++; $display("FAIL two_done got=%b/%0d exp=00/0", slots_busy, occ); end
        cyc(0, 1, 0, 8'h00, 8'h99);
        total++; if (slots_busy !== 2'b00 || occ !== 3'd1) begin
            bad++; $display("FAIL two_third_ignored got=%b/%0d exp=00/1", slots_busy, occ); end
        total++; if (data_out_vld !== 1'b0 || prop_signal !== 1'b1) begin
            bad++; $display("FAIL two_third_exit got=%b/%b exp=0/1", data_out_vld, prop_signal); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'(i), 8'h00);
        cyc(1, 1, 0, 8'h44, 8'h00);
        total++; if (occ !== 3'd4) begin bad++; $display("FAIL ovf_full got=%0d exp=4", occ); end
        cyc(1, 0, 1, 8'h55, 8'h00);
        total++; if (occ !== 3'd4 || err_overflow !== 1'b0) begin
            bad++; $display("FAIL ovf_pushpop got=%0d/%b exp=4/0", occ, err_overflow); end
        cyc(0, 0, 0, 8'h00, 8'h00);
        total++; if (occ !== 3'd4 || err_overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_flag got=%0d/%b exp=4/1", occ, err_overflow); end
        total++; if (slots_busy !== 2'b00) begin
            bad++; $display("FAIL ovf_no_capture got=%b exp=00", slots_busy); end
        cyc(0, 0, 0, 8'h00, 8'h00);
        total++; if (err_overflow !== 1'b1 || err_underflow !== 1'b0) begin
            bad++; $display("FAIL ovf_sticky got=%b/%b exp=1/0", err_overflow, err_underflow); end
    endtask

    task automatic test_underflow_and_reset();
        do_reset();
        cyc(0, 1, 0, 8'h00, 8'h00);
        cyc(1, 1, 1, 8'h77, 8'h00);
        total++; if (err_underflow !== 1'b1 || occ !== 3'd0) begin
            bad++; $display("FAIL udf_flag got=%b/%0d exp=1/0", err_underflow, occ); end
        cyc(0, 1, 0, 8'h00, 8'h00);
        total++; if (occ !== 3'd1 || slots_busy !== 2'b01) begin
            bad++; $display("FAIL udf_pushpop got=%0d/%b exp=1/01", occ, slots_busy); end
        total++; if (data_out_vld !== 1'b1 || prop_signal !== 1'b0) begin
            bad++; $display("FAIL udf_exit got=%b/%b exp=1/0", data_out_vld, prop_signal); end
        rst = 1'b0;
        #1;
        total++; if (data_out_vld !== 1'b0 || prop_signal !== 1'b1 || exit_slot !== 1'b0) begin
            bad++; $display("FAIL rst_mid_comb got=%b/%b/%h exp=0/1/0", data_out_vld, prop_signal, exit_slot); end
        total++; if (occ !== 3'd0 || slots_busy !== 2'b00 || err_underflow !== 1'b0 || err_overflow !== 1'b0) begin
            bad++; $display("FAIL rst_mid_reg got=%0d/%b/%b/%b exp=0/00/0/0", occ, slots_busy, err_underflow, err_overflow); end
        @(negedge clk);
        bus.pop = 0;
        rst = 1'b1;
    endtask

    initial begin
        bus.push = 0; bus.pop = 0; bus.start = 0; bus.data_in = 0; bus.data_out = 0;
        test_reset();
        test_single_match();
        test_single_mismatch();
        test_two_captures();
        test_overflow();
        test_underflow_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
